// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory access per instruction, formats load data for WB.
// Latency: IDLE->BUSY->DONE, 3 cycles minimum; BUSY waits for i_dmem_ack or TIMEOUT cycles (bus error).
// Backpressure: o_stall holds the pipeline while an access is outstanding; MEM_ALIGN_CHECK_EN enables misalign trapping.
module mem_stage_lsu #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic [1:0]  i_MEM_ctrl_Size,
    input  logic        i_MEM_ctrl_Unsigned,
    input  logic [31:0] i_MEM_data_Addr,
    input  logic [31:0] i_MEM_data_StoreData,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_WB_data_MemData,
    output logic        o_stall,
    output logic        o_bus_err,
    output logic        o_misalign
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [1:0]  ld_lane;
    logic [1:0]  ld_size;
    logic        ld_uns;
    logic        access, misalign_det, start, ack_done, tmo;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [1:0]  lane_nxt;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    assign access = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_det = ((i_MEM_ctrl_Size == 2'b01) && i_MEM_data_Addr[0]) ||
                          (i_MEM_ctrl_Size[1] && (i_MEM_data_Addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) o_misalign <= 1'b0;
        else       o_misalign <= (state == S_IDLE) && access && misalign_det;
    end
`else
    assign misalign_det = 1'b0;
    assign o_misalign   = 1'b0;
`endif

    assign start    = (state == S_IDLE) && access && !misalign_det;
    assign ack_done = (state == S_BUSY) && i_dmem_ack;
    // ack has priority over a timeout landing in the same cycle
    assign tmo      = (state == S_BUSY) && !i_dmem_ack && (cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_nxt = S_BUSY;
                o_stall   = 1'b1;
            end
            S_BUSY: begin
                o_stall = 1'b1;
                if (ack_done || tmo) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request formatting: byte/half data replicated across all lanes, enables pick the lane
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = i_MEM_data_StoreData;
        lane_nxt  = 2'b00;
        case (i_MEM_ctrl_Size)
            2'b00: begin
                be_nxt    = 4'b0001 << i_MEM_data_Addr[1:0];
                wdata_nxt = {4{i_MEM_data_StoreData[7:0]}};
                lane_nxt  = i_MEM_data_Addr[1:0];
            end
            2'b01: begin
                be_nxt    = 4'b0011 << {i_MEM_data_Addr[1], 1'b0};
                wdata_nxt = {2{i_MEM_data_StoreData[15:0]}};
                lane_nxt  = {i_MEM_data_Addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign shifted = i_dmem_rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_data = i_dmem_rdata;
        case (ld_size)
            2'b00:   ld_data = ld_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            2'b01:   ld_data = ld_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= S_IDLE;
            cnt               <= 8'd0;
            o_dmem_req        <= 1'b0;
            o_dmem_we         <= 1'b0;
            o_dmem_addr       <= 32'd0;
            o_dmem_wdata      <= 32'd0;
            o_dmem_be         <= 4'd0;
            o_WB_data_MemData <= 32'd0;
            o_bus_err         <= 1'b0;
            ld_lane           <= 2'd0;
            ld_size           <= 2'd0;
            ld_uns            <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_bus_err <= tmo;
            if (start) begin
                o_dmem_req   <= 1'b1;
                o_dmem_we    <= i_MEM_ctrl_MemWrite;
                o_dmem_addr  <= {i_MEM_data_Addr[31:2], 2'b00};
                o_dmem_be    <= be_nxt;
                o_dmem_wdata <= wdata_nxt;
                ld_lane      <= lane_nxt;
                ld_size      <= i_MEM_ctrl_Size;
                ld_uns       <= i_MEM_ctrl_Unsigned;
                cnt          <= 8'd0;
            end
            if (state == S_BUSY) begin
                if (ack_done || tmo) o_dmem_req <= 1'b0;
                else                 cnt        <= cnt + 8'd1;
            end
            if (state == S_DONE) cnt <= 8'd0;
            // o_dmem_we doubles as the load/store flag of the access in flight
            if (ack_done && !o_dmem_we)  o_WB_data_MemData <= ld_data;
            else if (tmo && !o_dmem_we)  o_WB_data_MemData <= 32'd0;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with TIMEOUT=4; request/result scoreboard queues.
module tb_mem_stage_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_MEM_ctrl_MemRead = 1'b0;
    logic        i_MEM_ctrl_MemWrite = 1'b0;
    logic [1:0]  i_MEM_ctrl_Size = 2'b00;
    logic        i_MEM_ctrl_Unsigned = 1'b0;
    logic [31:0] i_MEM_data_Addr = 32'd0;
    logic [31:0] i_MEM_data_StoreData = 32'd0;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = 32'd0;
    logic [31:0] o_WB_data_MemData;
    logic        o_stall, o_bus_err, o_misalign;

    mem_stage_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst),
        .i_MEM_ctrl_MemRead(i_MEM_ctrl_MemRead), .i_MEM_ctrl_MemWrite(i_MEM_ctrl_MemWrite),
        .i_MEM_ctrl_Size(i_MEM_ctrl_Size), .i_MEM_ctrl_Unsigned(i_MEM_ctrl_Unsigned),
        .i_MEM_data_Addr(i_MEM_data_Addr), .i_MEM_data_StoreData(i_MEM_data_StoreData),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_WB_data_MemData(o_WB_data_MemData),
        .o_stall(o_stall), .o_bus_err(o_bus_err), .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    req_t        req_q[$];
    logic [31:0] res_q[$];
    logic [31:0] last_mem = 32'd0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        if (sz == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return rd;
    endfunction

    // delay < 0 withholds ack entirely; otherwise ack arrives in BUSY cycle delay+1
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd,
                          input int delay, input logic [31:0] rdata);
        req_t        r;
        logic [31:0] exp_res;
        int          busy;
        int          stalls = 0;
        r.addr  = {a[31:2], 2'b00};
        r.be    = m_be(sz, a);
        r.wdata = m_wd(sz, sd);
        r.we    = wr;
        req_q.push_back(r);
        if (wr)             exp_res = last_mem;
        else if (delay < 0) exp_res = 32'd0;
        else                exp_res = m_ld(sz, uns, a, rdata);
        res_q.push_back(exp_res);
        last_mem = exp_res;

        i_MEM_ctrl_MemRead   = rd;
        i_MEM_ctrl_MemWrite  = wr;
        i_MEM_ctrl_Size      = sz;
        i_MEM_ctrl_Unsigned  = uns;
        i_MEM_data_Addr      = a;
        i_MEM_data_StoreData = sd;
        #1;
        chk({tag, ":stall_idle"}, 32'(o_stall), 32'd1);
        if (o_stall) stalls++;
        busy = (delay < 0) ? TMO : delay + 1;
        tick();
        for (int i = 0; i < busy; i++) begin
            if (o_stall) stalls++;
            chk({tag, ":req_busy"}, 32'(o_dmem_req), 32'd1);
            if (i == 0) begin
                r = req_q.pop_front();
                chk({tag, ":addr"},  o_dmem_addr,       r.addr);
                chk({tag, ":be"},    32'(o_dmem_be),    32'(r.be));
                chk({tag, ":wdata"}, o_dmem_wdata,      r.wdata);
                chk({tag, ":we"},    32'(o_dmem_we),    32'(r.we));
            end
            if (i == busy - 1 && delay >= 0) begin
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = rdata;
            end
            tick();
        end
        i_dmem_ack           = 1'b0;
        i_dmem_rdata         = 32'h5A5A_5A5A;
        i_MEM_ctrl_MemRead   = 1'b0;
        i_MEM_ctrl_MemWrite  = 1'b0;
        #1;
        chk({tag, ":req_done"},   32'(o_dmem_req), 32'd0);
        chk({tag, ":stall_done"}, 32'(o_stall),    32'd0);
        chk({tag, ":bus_err"},    32'(o_bus_err),  (delay < 0) ? 32'd1 : 32'd0);
        chk({tag, ":memdata"},    o_WB_data_MemData, res_q.pop_front());
        chk({tag, ":stall_cycles"}, 32'(stalls), 32'(busy + 1));
        tick();
        chk({tag, ":bus_err_pulse"}, 32'(o_bus_err),  32'd0);
        chk({tag, ":req_idle"},      32'(o_dmem_req), 32'd0);
        chk({tag, ":memdata_hold"},  o_WB_data_MemData, last_mem);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst:req",     32'(o_dmem_req),  32'd0);
        chk("rst:we",      32'(o_dmem_we),   32'd0);
        chk("rst:addr",    o_dmem_addr,      32'd0);
        chk("rst:wdata",   o_dmem_wdata,     32'd0);
        chk("rst:be",      32'(o_dmem_be),   32'd0);
        chk("rst:memdata", o_WB_data_MemData, 32'd0);
        chk("rst:bus_err", 32'(o_bus_err),   32'd0);
        chk("rst:misalign", 32'(o_misalign), 32'd0);
        nrst = 1'b1;
        tick();
        chk("idle:stall", 32'(o_stall), 32'd0);
        tick();
        chk("idle:req", 32'(o_dmem_req), 32'd0);

        access("lb_signed",   1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,         0,  32'h80FF_FF12);
        access("sh",          0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 1,  32'h0);
        access("lhu",         1, 0, 2'b01, 1, 32'h0000_0102, 32'h0,         2,  32'h8001_1234);
        access("lh_signed",   1, 0, 2'b01, 0, 32'h0000_0100, 32'h0,         0,  32'h0000_F00F);
        access("sb",          0, 1, 2'b00, 0, 32'h0000_0301, 32'h0000_00AB, 0,  32'h0);
        access("sw",          0, 1, 2'b10, 0, 32'h0000_0400, 32'h1234_5678, 0,  32'h0);
        access("lbu",         1, 0, 2'b00, 1, 32'h0000_0102, 32'h0,         1,  32'h00A5_0000);
        access("lw_timeout",  1, 0, 2'b10, 0, 32'h0000_0500, 32'h0,         -1, 32'h0);
        access("lw_ack_last", 1, 0, 2'b10, 0, 32'h0000_0504, 32'h0,         TMO - 1, 32'hDEAD_BEEF);
        access("rd_wr_both",  1, 1, 2'b10, 0, 32'h0000_0600, 32'hCAFE_F00D, 0,  32'h1111_2222);
        access("size11_lw",   1, 0, 2'b11, 1, 32'h0000_0608, 32'h0,         0,  32'h8765_4321);

`ifdef MEM_ALIGN_CHECK_EN
        i_MEM_ctrl_MemRead = 1'b1;
        i_MEM_ctrl_Size    = 2'b10;
        i_MEM_data_Addr    = 32'h0000_0101;
        #1;
        chk("mis:stall", 32'(o_stall), 32'd0);
        tick();
        i_MEM_ctrl_MemRead = 1'b0;
        chk("mis:pulse",   32'(o_misalign),  32'd1);
        chk("mis:req",     32'(o_dmem_req),  32'd0);
        chk("mis:memdata", o_WB_data_MemData, last_mem);
        tick();
        chk("mis:pulse_end", 32'(o_misalign), 32'd0);
        chk("mis:req_after", 32'(o_dmem_req), 32'd0);
`else
        access("lw_unaligned", 1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 0, 32'h1122_3344);
        chk("mis:tied0", 32'(o_misalign), 32'd0);
`endif

        // reset abandons an access in BUSY; a late ack afterwards is ignored
        i_MEM_ctrl_MemRead = 1'b1;
        i_MEM_ctrl_Size    = 2'b10;
        i_MEM_data_Addr    = 32'h0000_0700;
        tick();
        chk("rstbusy:req_before", 32'(o_dmem_req), 32'd1);
        #2;
        nrst = 1'b0;
        i_MEM_ctrl_MemRead = 1'b0;
        #1;
        chk("rstbusy:req",     32'(o_dmem_req),  32'd0);
        chk("rstbusy:addr",    o_dmem_addr,      32'd0);
        chk("rstbusy:be",      32'(o_dmem_be),   32'd0);
        chk("rstbusy:memdata", o_WB_data_MemData, 32'd0);
        chk("rstbusy:stall",   32'(o_stall),     32'd0);
        nrst         = 1'b1;
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hDEAD_BEEF;
        tick();
        i_dmem_ack = 1'b0;
        chk("lateack:req",     32'(o_dmem_req),  32'd0);
        chk("lateack:memdata", o_WB_data_MemData, 32'd0);
        chk("lateack:stall",   32'(o_stall),     32'd0);
        chk("lateack:bus_err", 32'(o_bus_err),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
